// File: rtl/line_drawer.sv
// Bresenham line engine: captures two endpoints and a colour, emits one pixel per cycle to the VGA plot port.
// Latency: first pixel 2 cycles after start, N pixels back to back, done pulse 1 cycle after the last pixel.
// No backpressure: the consumer must accept every plotted pixel; i_start is ignored while busy.
module line_drawer (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_start,
    input  logic [8:0] i_x0,
    input  logic [7:0] i_y0,
    input  logic [8:0] i_x1,
    input  logic [7:0] i_y1,
    input  logic [2:0] i_color,
    output logic [8:0] o_x,
    output logic [7:0] o_y,
    output logic [2:0] o_color,
    output logic       o_plot,
    output logic       o_busy,
    output logic       o_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_DRAW,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;

    // Endpoints captured on the start cycle so the inputs may change afterwards.
    logic [8:0] cap_x0;
    logic [7:0] cap_y0;
    logic [8:0] cap_x1;
    logic [7:0] cap_y1;

    // Walk state in the (possibly swapped) frame: xa walks toward xb one step per pixel.
    logic [8:0]        xa;
    logic [8:0]        xb;
    logic [8:0]        y;
    logic [8:0]        dx;
    logic [8:0]        dy;
    logic signed [10:0] err;
    logic              steep;
    logic              ystep_up;

    // Setup values derived from the captured endpoints during INIT.
    logic [8:0]         ax, ay, bx, by;
    logic [8:0]         adx, ady;
    logic               init_steep;
    logic [8:0]         p0x, p0y, p1x, p1y;
    logic [8:0]         sa_x, sa_y, sb_x, sb_y;
    logic [8:0]         init_dx, init_dy;
    logic               init_up;
    logic signed [10:0] init_err;

    // Per-pixel step values during DRAW.
    logic signed [10:0] err_sum;
    logic               step_y;
    logic [8:0]         y_step;
    logic [8:0]         y_next;
    logic signed [10:0] err_next;
    logic [8:0]         xa_next;

    assign o_busy = (state != S_IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: one INIT cycle, DRAW until the far endpoint is plotted, one DONE cycle.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (i_start) state_next = S_INIT;
            S_INIT: state_next = S_DRAW;
            S_DRAW: if (xa == xb) state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Octant normalisation: swap axes for steep lines, then order endpoints so X increases.
    always_comb begin
        ax = cap_x0;
        ay = {1'b0, cap_y0};
        bx = cap_x1;
        by = {1'b0, cap_y1};
        adx = (ax >= bx) ? (ax - bx) : (bx - ax);
        ady = (ay >= by) ? (ay - by) : (by - ay);
        init_steep = (ady > adx);
        p0x = init_steep ? ay : ax;
        p0y = init_steep ? ax : ay;
        p1x = init_steep ? by : bx;
        p1y = init_steep ? bx : by;
        if (p0x > p1x) begin
            sa_x = p1x;
            sa_y = p1y;
            sb_x = p0x;
            sb_y = p0y;
        end else begin
            sa_x = p0x;
            sa_y = p0y;
            sb_x = p1x;
            sb_y = p1y;
        end
        init_dx  = sb_x - sa_x;
        init_up  = (sa_y < sb_y);
        init_dy  = init_up ? (sb_y - sa_y) : (sa_y - sb_y);
        init_err = 11'sd0 - $signed({3'b000, init_dx[8:1]});
    end

    // Bresenham step: the error decides whether the minor axis advances for the next pixel.
    always_comb begin
        err_sum  = err + $signed({2'b00, dy});
        step_y   = ~err_sum[10];
        y_step   = ystep_up ? (y + 9'd1) : (y - 9'd1);
        y_next   = step_y ? y_step : y;
        err_next = step_y ? (err_sum - $signed({2'b00, dx})) : err_sum;
        xa_next  = xa + 9'd1;
    end

    // Datapath and registered outputs; the pixel for each DRAW cycle is loaded on the preceding edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            cap_x0   <= '0;
            cap_y0   <= '0;
            cap_x1   <= '0;
            cap_y1   <= '0;
            xa       <= '0;
            xb       <= '0;
            y        <= '0;
            dx       <= '0;
            dy       <= '0;
            err      <= '0;
            steep    <= 1'b0;
            ystep_up <= 1'b0;
            o_x      <= '0;
            o_y      <= '0;
            o_color  <= '0;
            o_plot   <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            o_plot <= 1'b0;
            o_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        cap_x0  <= i_x0;
                        cap_y0  <= i_y0;
                        cap_x1  <= i_x1;
                        cap_y1  <= i_y1;
                        o_color <= i_color;
                    end
                end
                S_INIT: begin
                    xa       <= sa_x;
                    xb       <= sb_x;
                    y        <= sa_y;
                    dx       <= init_dx;
                    dy       <= init_dy;
                    err      <= init_err;
                    steep    <= init_steep;
                    ystep_up <= init_up;
                    o_plot   <= 1'b1;
                    o_x      <= init_steep ? sa_y : sa_x;
                    o_y      <= init_steep ? sa_x[7:0] : sa_y[7:0];
                end
                S_DRAW: begin
                    if (xa == xb) begin
                        o_done <= 1'b1;
                    end else begin
                        xa     <= xa_next;
                        y      <= y_next;
                        err    <= err_next;
                        o_plot <= 1'b1;
                        o_x    <= steep ? y_next : xa_next;
                        o_y    <= steep ? xa_next[7:0] : y_next[7:0];
                    end
                end
                S_DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_drawer.sv
// Directed testbench for line_drawer: reset, octant lines, full-frame line, held start, mid-line reset.
// Latency: checks first pixel at start+2, contiguous pixels, done at start+N+2, idle at start+N+3.
// Backpressure: none in the DUT; the bench only observes outputs one time unit after each rising edge.
module tb_line_drawer;

    logic       clk;
    logic       reset;
    logic       i_start;
    logic [8:0] i_x0;
    logic [7:0] i_y0;
    logic [8:0] i_x1;
    logic [7:0] i_y1;
    logic [2:0] i_color;
    logic [8:0] o_x;
    logic [7:0] o_y;
    logic [2:0] o_color;
    logic       o_plot;
    logic       o_busy;
    logic       o_done;

    int tests_run = 0;
    int tests_failed = 0;

    // Results of the most recent collected line.
    int px [512];
    int py [512];
    int pc [512];
    int n_plot;
    int first_c;
    int last_c;
    int done_c;
    int done_after;
    int busy_after;
    int init_busy;
    int init_plot;

    // Directed line table: endpoints, colour, pixel count and offset into the pixel tables.
    int lx0 [4] = '{0, 10, 0, 5};
    int ly0 [4] = '{0, 20, 3, 5};
    int lx1 [4] = '{4, 8, 6, 5};
    int ly1 [4] = '{0, 14, 0, 5};
    int lcol[4] = '{5, 3, 6, 7};
    int lnum[4] = '{5, 7, 7, 1};
    int loff[4] = '{0, 5, 12, 19};
    int ex  [20] = '{0, 1, 2, 3, 4,  8, 8, 9, 9, 9, 10, 10,  0, 1, 2, 3, 4, 5, 6,  5};
    int ey  [20] = '{0, 0, 0, 0, 0,  14, 15, 16, 17, 18, 19, 20,  3, 2, 2, 1, 1, 0, 0,  5};

    line_drawer dut (
        .clk     (clk),
        .reset   (reset),
        .i_start (i_start),
        .i_x0    (i_x0),
        .i_y0    (i_y0),
        .i_x1    (i_x1),
        .i_y1    (i_y1),
        .i_color (i_color),
        .o_x     (o_x),
        .o_y     (o_y),
        .o_color (o_color),
        .o_plot  (o_plot),
        .o_busy  (o_busy),
        .o_done  (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Pulses i_start for one edge; returns in the INIT cycle (start+1).
    task automatic start_line(input int x0, input int y0, input int x1, input int y1, input int col);
        i_x0    = x0[8:0];
        i_y0    = y0[7:0];
        i_x1    = x1[8:0];
        i_y1    = y1[7:0];
        i_color = col[2:0];
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    // Records plotted pixels with their cycle offsets from the start edge until done or budget.
    task automatic collect(input int budget);
        int c;
        c = 1;
        n_plot = 0;
        first_c = -1;
        last_c = -1;
        done_c = -1;
        done_after = -1;
        busy_after = -1;
        init_busy = int'(o_busy);
        init_plot = int'(o_plot);
        while (done_c < 0 && c < budget) begin
            tick();
            c++;
            if (o_plot) begin
                if (n_plot < 512) begin
                    px[n_plot] = int'(o_x);
                    py[n_plot] = int'(o_y);
                    pc[n_plot] = int'(o_color);
                end
                n_plot++;
                if (first_c < 0) first_c = c;
                last_c = c;
            end
            if (o_done) done_c = c;
        end
        if (done_c >= 0) begin
            tick();
            done_after = int'(o_done);
            busy_after = int'(o_busy);
        end
    endtask

    task automatic test_reset;
        i_start = 1'b0;
        i_x0 = '0; i_y0 = '0; i_x1 = '0; i_y1 = '0; i_color = '0;
        reset = 1'b1;
        tick();
        tick();
        tests_run++;
        if (o_plot !== 1'b0 || o_done !== 1'b0 || o_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: plot=%b done=%b busy=%b, required 0 0 0", o_plot, o_done, o_busy);
        end
        tests_run++;
        if (o_x !== 9'd0 || o_y !== 8'd0 || o_color !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_data: x=%0d y=%0d color=%0d, required 0 0 0", o_x, o_y, o_color);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_directed_lines;
        for (int k = 0; k < 4; k++) begin
            int bad;
            start_line(lx0[k], ly0[k], lx1[k], ly1[k], lcol[k]);
            collect(60);
            tests_run++;
            if (done_c < 0) begin
                tests_failed++;
                $display("FAIL line%0d_timeout: no done pulse within budget, required one", k);
            end
            tests_run++;
            if (init_busy !== 1 || init_plot !== 0) begin
                tests_failed++;
                $display("FAIL line%0d_init: busy=%0d plot=%0d, required 1 0", k, init_busy, init_plot);
            end
            tests_run++;
            if (n_plot !== lnum[k]) begin
                tests_failed++;
                $display("FAIL line%0d_count: got %0d pixels, required %0d", k, n_plot, lnum[k]);
            end
            tests_run++;
            if (first_c !== 2 || last_c !== lnum[k] + 1) begin
                tests_failed++;
                $display("FAIL line%0d_window: plots %0d..%0d, required 2..%0d", k, first_c, last_c, lnum[k] + 1);
            end
            bad = 0;
            for (int i = 0; i < lnum[k] && i < n_plot; i++) begin
                tests_run++;
                if (px[i] !== ex[loff[k] + i] || py[i] !== ey[loff[k] + i] || pc[i] !== lcol[k]) begin
                    tests_failed++;
                    $display("FAIL line%0d_pix%0d: got (%0d,%0d) c%0d, required (%0d,%0d) c%0d",
                             k, i, px[i], py[i], pc[i], ex[loff[k] + i], ey[loff[k] + i], lcol[k]);
                end
            end
            tests_run++;
            if (done_c !== lnum[k] + 2 || done_after !== 0 || busy_after !== 0) begin
                tests_failed++;
                $display("FAIL line%0d_done: done at %0d then done=%0d busy=%0d, required %0d then 0 0",
                         k, done_c, done_after, busy_after, lnum[k] + 2);
            end
        end
    endtask

    task automatic test_full_frame;
        int bad_step;
        int bad_range;
        int has_a;
        int has_b;
        start_line(319, 0, 0, 239, 2);
        collect(400);
        tests_run++;
        if (done_c !== 322) begin
            tests_failed++;
            $display("FAIL frame_done: done at %0d, required 322", done_c);
        end
        tests_run++;
        if (n_plot !== 320) begin
            tests_failed++;
            $display("FAIL frame_count: got %0d pixels, required 320", n_plot);
        end
        bad_step = 0;
        bad_range = 0;
        has_a = 0;
        has_b = 0;
        for (int i = 0; i < n_plot && i < 512; i++) begin
            if (px[i] > 319 || py[i] > 239) bad_range++;
            if (px[i] == 319 && py[i] == 0) has_a = 1;
            if (px[i] == 0 && py[i] == 239) has_b = 1;
            if (i > 0) begin
                int ddx;
                int ddy;
                ddx = px[i] - px[i-1];
                ddy = py[i] - py[i-1];
                if (!(ddx == 1 || ddx == -1) || ddy > 1 || ddy < -1) bad_step++;
            end
        end
        tests_run++;
        if (has_a !== 1 || has_b !== 1) begin
            tests_failed++;
            $display("FAIL frame_endpoints: saw (319,0)=%0d (0,239)=%0d, required 1 1", has_a, has_b);
        end
        tests_run++;
        if (bad_step !== 0) begin
            tests_failed++;
            $display("FAIL frame_adjacency: %0d bad steps, required 0", bad_step);
        end
        tests_run++;
        if (bad_range !== 0) begin
            tests_failed++;
            $display("FAIL frame_range: %0d out-of-range pixels, required 0", bad_range);
        end
    endtask

    // Start held high: second 5-pixel line starts only once IDLE is re-entered at start+8.
    task automatic test_start_held;
        i_x0 = 9'd0; i_y0 = 8'd0; i_x1 = 9'd4; i_y1 = 8'd0; i_color = 3'd3;
        i_start = 1'b1;
        tick();
        for (int c = 1; c <= 16; c++) begin
            logic exp_plot;
            logic exp_done;
            exp_plot = ((c >= 2 && c <= 6) || (c >= 10 && c <= 14));
            exp_done = (c == 7 || c == 15);
            tests_run++;
            if (o_plot !== exp_plot || o_done !== exp_done) begin
                tests_failed++;
                $display("FAIL held_c%0d_ctrl: plot=%b done=%b, required %b %b", c, o_plot, o_done, exp_plot, exp_done);
            end
            if (exp_plot && o_plot === 1'b1) begin
                int exp_x;
                exp_x = (c < 10) ? c - 2 : c - 10;
                tests_run++;
                if (int'(o_x) !== exp_x || o_y !== 8'd0) begin
                    tests_failed++;
                    $display("FAIL held_c%0d_pix: got (%0d,%0d), required (%0d,0)", c, o_x, o_y, exp_x);
                end
            end
            if (c < 16) tick();
        end
        i_start = 1'b0;
        tick();
        tests_run++;
        if (o_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL held_idle: busy=%b after release, required 0", o_busy);
        end
    endtask

    task automatic test_reset_midline;
        int stray;
        start_line(0, 0, 9, 9, 4);
        tick();
        tick();
        tick();
        tests_run++;
        if (o_plot !== 1'b1 || o_x !== 9'd2 || o_y !== 8'd2) begin
            tests_failed++;
            $display("FAIL midrst_third: plot=%b (%0d,%0d), required 1 (2,2)", o_plot, o_x, o_y);
        end
        reset = 1'b1;
        tick();
        tests_run++;
        if (o_plot !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_cut: plot=%b busy=%b done=%b, required 0 0 0", o_plot, o_busy, o_done);
        end
        reset = 1'b0;
        stray = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (o_done !== 1'b0 || o_plot !== 1'b0 || o_busy !== 1'b0) stray++;
        end
        tests_run++;
        if (stray !== 0) begin
            tests_failed++;
            $display("FAIL midrst_quiet: %0d cycles with activity after reset, required 0", stray);
        end
        start_line(2, 1, 0, 0, 1);
        collect(20);
        tests_run++;
        if (n_plot !== 3 || done_c !== 5 || busy_after !== 0) begin
            tests_failed++;
            $display("FAIL midrst_restart: count=%0d done=%0d busy=%0d, required 3 5 0", n_plot, done_c, busy_after);
        end
        tests_run++;
        if (px[0] !== 0 || py[0] !== 0 || px[1] !== 1 || py[1] !== 1 || px[2] !== 2 || py[2] !== 1 || pc[0] !== 1) begin
            tests_failed++;
            $display("FAIL midrst_pixels: got (%0d,%0d)(%0d,%0d)(%0d,%0d) c%0d, required (0,0)(1,1)(2,1) c1",
                     px[0], py[0], px[1], py[1], px[2], py[2], pc[0]);
        end
    endtask

    initial begin
        reset = 1'b1;
        i_start = 1'b0;
        test_reset();
        test_directed_lines();
        test_full_frame();
        test_start_held();
        test_reset_midline();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/line_drawer.md
# line_drawer

Bresenham line engine sitting directly downstream of the UI datapath in the lab3 line-drawing design. On a start pulse it captures the endpoint pair (x0,y0)->(x1,y1) and 3-bit colour, then emits one pixel per cycle to the VGA adapter's plot port until the line is complete. It handles all eight octants and signals completion with a one-cycle done pulse so the control FSM can accept the next command.

## Interface
- No parameters; widths fixed to the 320x240 frame (X 9 bits, Y 8 bits, colour 3 bits).
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high; returns block to IDLE.
- i_start  input  1  request to draw; sampled only in IDLE.
- i_x0  input  9  start X (0..319).
- i_y0  input  8  start Y (0..239).
- i_x1  input  9  end X.
- i_y1  input  8  end Y.
- i_color  input  3  pixel colour.
- o_x  output  9  pixel X to VGA adapter.
- o_y  output  8  pixel Y to VGA adapter.
- o_color  output  3  pixel colour (captured i_color).
- o_plot  output  1  write-enable for current o_x/o_y/o_color.
- o_busy  output  1  high in every state except IDLE.
- o_done  output  1  one-cycle pulse after last pixel.

## Operation
- States: IDLE -> INIT -> DRAW -> DONE -> IDLE.
- IDLE: i_start=1 latches i_x0..i_y1 and i_color; next state INIT. i_start=0 stays IDLE.
- INIT (1 cycle): steep = |y1-y0| > |x1-x0|. If steep, swap x/y of each endpoint. Then if x0 > x1, swap endpoints. Register xa=x0, xb=x1, y=y0, dx=xb-xa (unsigned, 9 bits), dy=|y1-y0| (9 bits), ystep=+1 if y0<y1 else -1, err = -(dx>>1).
- DRAW: each cycle o_plot=1 with (o_x,o_y)=(y,xa) if steep else (xa,y). Update: err+=dy; if new err >= 0 then y+=ystep, err-=dx. If xa==xb this is the last pixel, next DONE; else xa+=1.
- Internal coordinates 9 bits (swapped Y occupies an X-width slot); err is 11-bit signed, sufficient for dx,dy <= 319.
- Pixel count N = max(|x1-x0|,|y1-y0|)+1; first and last pixels equal the two endpoints (order may be reversed when endpoints are swapped).
- DONE (1 cycle): o_done=1, o_plot=0; next IDLE. i_start during DONE ignored.
- i_start while busy (INIT/DRAW/DONE) ignored; no queuing. Input ports need not be held stable after the start cycle.
- o_color constant for the whole line.

## Timing
- Reset values: state IDLE, o_plot=0, o_done=0, o_busy=0, o_x=0, o_y=0, o_color=0.
- Start sampled at edge k: INIT during cycle k+1; o_plot high cycles k+2 .. k+N+1 (N consecutive cycles, no gaps); o_done high cycle k+N+2; IDLE at k+N+3, earliest new start sampled at the end of that cycle.
- Total occupancy N+3 cycles per line; throughput one pixel/cycle.
- Outputs registered; o_x/o_y/o_plot change only on clock edges.
- Reset asserted mid-line: next edge forces IDLE, o_plot=0 that cycle onward, no o_done pulse, remaining pixels discarded.
- o_x/o_y/o_color hold last value when o_plot=0 (don't-care to consumer).

## Test plan
- Horizontal (0,0)->(4,0), colour 5 -> o_plot high 5 cycles starting 2 cycles after start, pixels (0,0),(1,0),(2,0),(3,0),(4,0), o_color=5, o_done one cycle later.
- Steep reversed (10,20)->(8,14) -> 7 pixels in order (8,14),(8,15),(9,16),(9,17),(9,18),(10,19),(10,20), then o_done.
- Single point (5,5)->(5,5) -> exactly one plot at (5,5), o_done at start+3, o_busy low at start+4.
- Full-frame (319,0)->(0,239) -> 320 plots, set includes (319,0) and (0,239), every consecutive pair differs by 1 in X and <=1 in Y, no coordinate out of range.
- i_start held high throughout a 5-pixel line -> second line starts only after IDLE is re-entered; no pixels of the first line lost or duplicated.
- Reset asserted on 3rd plot cycle of (0,0)->(9,9) -> o_plot low next cycle, o_done never pulses, o_busy=0; new start afterwards draws correctly.
